// File: rtl/neuron_acc.sv
// neuron_acc: binary-weight neuron accumulator.
// Accumulates the dot product of LANES unsigned activations with +/-1 weights
// over one or more beats per frame. At the end of the frame it applies an
// arithmetic right shift (alpha), optional ReLU and symmetric saturation, then
// presents a signed WIDTH_OUT result over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_last             marks the final beat of a frame
//   activations         LANES x WIDTH_IN unsigned activations, lane i at [i]
//   weights             per lane: 1 = +act, 0 = -act
//   alpha, relu_en      frame parameters, captured on the first beat
//   out_valid/out_ready result handshake
//   out_data            signed saturated result
//   beat_overflow       sticky: a frame was forced closed at MAX_BEATS
module neuron_acc #(
    parameter int unsigned WIDTH_IN  = 8,
    parameter int unsigned LANES     = 64,
    parameter int unsigned WIDTH_OUT = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned ALPHA_W   = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [LANES*WIDTH_IN-1:0]     activations,
    input  logic [LANES-1:0]              weights,
    input  logic [ALPHA_W-1:0]            alpha,
    input  logic                          relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH_OUT-1:0]   out_data,
    output logic                          beat_overflow
);

    // Wide enough that a full frame of maximal activations cannot overflow.
    localparam int unsigned ACC_W = WIDTH_IN + $clog2(LANES) + $clog2(MAX_BEATS) + 1;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS);

    localparam logic signed [ACC_W-1:0]     SAT_POS     = ACC_W'((1 << (WIDTH_OUT - 1)) - 1);
    localparam logic signed [ACC_W-1:0]     SAT_NEG     = -SAT_POS;
    localparam logic signed [WIDTH_OUT-1:0] SAT_POS_OUT = WIDTH_OUT'((1 << (WIDTH_OUT - 1)) - 1);
    localparam logic signed [WIDTH_OUT-1:0] SAT_NEG_OUT = -SAT_POS_OUT;
    localparam logic [CNT_W-1:0]            LAST_CNT    = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ACC,
        SAT,
        OUT
    } state_t;

    state_t                     state;
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           beat_cnt;
    logic [ALPHA_W-1:0]         alpha_q;
    logic                       relu_q;

    logic signed [ACC_W-1:0]    beat_sum;
    logic signed [ACC_W-1:0]    lane_val;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [WIDTH_OUT-1:0] result;

    // Signed sum of the current beat: each lane adds or subtracts its activation.
    always_comb begin
        beat_sum = '0;
        lane_val = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_val = ACC_W'(activations[i*WIDTH_IN +: WIDTH_IN]);
            beat_sum = weights[i] ? (beat_sum + lane_val) : (beat_sum - lane_val);
        end
    end

    // Post-processing of the closed frame. The arithmetic shift floors toward
    // -inf and saturates to 0/-1 for shift amounts beyond the accumulator width.
    always_comb begin
        shifted = acc >>> alpha_q;
        if (relu_q && shifted < 0)
            shifted = '0;
        if (shifted > SAT_POS)
            result = SAT_POS_OUT;
        else if (shifted < SAT_NEG)
            result = SAT_NEG_OUT;
        else
            result = WIDTH_OUT'(shifted);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACC;
            acc           <= '0;
            beat_cnt      <= '0;
            alpha_q       <= '0;
            relu_q        <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            beat_overflow <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        acc      <= ((beat_cnt == '0) ? '0 : acc) + beat_sum;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == '0) begin
                            alpha_q <= alpha;
                            relu_q  <= relu_en;
                        end
                        if (in_last || beat_cnt == LAST_CNT) begin
                            // Frame closed without in_last: flag the forced close.
                            if (!in_last)
                                beat_overflow <= 1'b1;
                            beat_cnt <= '0;
                            in_ready <= 1'b0;
                            state    <= SAT;
                        end
                    end
                end
                SAT: begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACC;
                    end
                end
                default: begin
                    state    <= ACC;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
